// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder leaf block: handshake tie-offs and
// default parameter values used by the interface and the top.
package full_adder_pkg;

    // ap_idle never deasserts because the block holds no busy state
    localparam logic AP_IDLE_CONST = 1'b1;

    // Default geometry: classic 1-bit full adder with a 16-bit transaction counter
    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/full_adder_if.sv
// ap_ctrl_hs handshake, operands, results and capture-stage observation
// signals of full_adder, bundled as one interface.
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             sum_ap_vld;
    logic             cout;
    logic             cout_ap_vld;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [CNT_W-1:0] txn_count;

    // Requester side: drives the request and operands
    modport master (
        output ap_start, a, b, cin,
        input  ap_done, ap_idle, ap_ready, sum, sum_ap_vld, cout, cout_ap_vld,
               sum_q, cout_q, txn_count
    );

    // Adder side: consumes the request, produces results
    modport slave (
        input  ap_start, a, b, cin,
        output ap_done, ap_idle, ap_ready, sum, sum_ap_vld, cout, cout_ap_vld,
               sum_q, cout_q, txn_count
    );

endinterface

// File: rtl/full_adder_fa_bit_cell.sv
// One-bit full adder cell; the top chains WIDTH of these into a ripple adder.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry-out
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Zero-latency ap_ctrl_hs ripple-carry adder with a registered capture
// stage holding the last accepted result and a transaction counter.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    full_adder_if.slave bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_q_reg;
    logic             cout_q_reg;
    logic [CNT_W-1:0] txn_count_reg;

    // Ripple chain: carry[gi] enters cell gi, carry[gi+1] leaves it
    assign carry[0] = bus.cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            fa_bit_cell u_cell (
                .a  (bus.a[gi]),
                .b  (bus.b[gi]),
                .ci (carry[gi]),
                .s  (sum_comb[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    // Results are not gated by ap_start; only the qualifiers follow it
    assign bus.sum         = sum_comb;
    assign bus.cout        = carry[WIDTH];
    assign bus.sum_ap_vld  = bus.ap_start;
    assign bus.cout_ap_vld = bus.ap_start;
    assign bus.ap_done     = bus.ap_start;
    assign bus.ap_ready    = bus.ap_start;
    assign bus.ap_idle     = AP_IDLE_CONST;

    // Capture the result of every accepted request; reset beats ap_start,
    // and with ap_start low the (possibly undefined) operands are ignored
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sum_q_reg     <= '0;
            cout_q_reg    <= 1'b0;
            txn_count_reg <= '0;
        end else if (bus.ap_start) begin
            sum_q_reg     <= sum_comb;
            cout_q_reg    <= carry[WIDTH];
            txn_count_reg <= txn_count_reg + CNT_W'(1);
        end
    end

    assign bus.sum_q     = sum_q_reg;
    assign bus.cout_q    = cout_q_reg;
    assign bus.txn_count = txn_count_reg;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit and a 4-bit instance driven side by side,
// checked every cycle against an arithmetic model plus directed literals.
module tb_full_adder;

    logic clk;
    logic rst;
    logic start;
    logic cmp_en;

    int checks;
    int errors;

    full_adder_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    full_adder_if #(.WIDTH(4), .CNT_W(16)) if4 ();

    assign if1.ap_start = start;
    assign if4.ap_start = start;

    full_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (if1)
    );

    full_adder #(.WIDTH(4), .CNT_W(16)) dut4 (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference capture state: the last accepted a+b+cin and a count of accepts
    int          m1_res;
    int          m4_res;
    logic [15:0] m_cnt;
    initial begin
        m1_res = 0;
        m4_res = 0;
        m_cnt  = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_res <= 0;
            m4_res <= 0;
            m_cnt  <= '0;
        end else if (start) begin
            m1_res <= int'(if1.a) + int'(if1.b) + int'(if1.cin);
            m4_res <= int'(if4.a) + int'(if4.b) + int'(if4.cin);
            m_cnt  <= m_cnt + 16'd1;
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int r1;
        int r4;
        if (cmp_en) begin
            r1 = int'(if1.a) + int'(if1.b) + int'(if1.cin);
            r4 = int'(if4.a) + int'(if4.b) + int'(if4.cin);
            chk("w1_sum",   32'(if1.sum),  32'(r1 % 2));
            chk("w1_cout",  32'(if1.cout), 32'(r1 / 2));
            chk("w4_sum",   32'(if4.sum),  32'(r4 % 16));
            chk("w4_cout",  32'(if4.cout), 32'(r4 / 16));
            chk("w1_vld",   {29'd0, if1.sum_ap_vld, if1.cout_ap_vld, if1.ap_done},
                            {29'd0, start, start, start});
            chk("w1_ready", 32'(if1.ap_ready), 32'(start));
            chk("w4_hs",    {28'd0, if4.sum_ap_vld, if4.cout_ap_vld, if4.ap_done, if4.ap_ready},
                            {28'd0, start, start, start, start});
            chk("idle",     {30'd0, if1.ap_idle, if4.ap_idle}, 32'd3);
            chk("w1_sum_q",  32'(if1.sum_q),  32'(m1_res % 2));
            chk("w1_cout_q", 32'(if1.cout_q), 32'(m1_res / 2));
            chk("w4_sum_q",  32'(if4.sum_q),  32'(m4_res % 16));
            chk("w4_cout_q", 32'(if4.cout_q), 32'(m4_res / 16));
            chk("w1_txn",    32'(if1.txn_count), 32'(m_cnt));
            chk("w4_txn",    32'(if4.txn_count), 32'(m_cnt));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_w4();
        if4.a   = 4'($urandom_range(0, 15));
        if4.b   = 4'($urandom_range(0, 15));
        if4.cin = 1'($urandom_range(0, 1));
    endtask

    logic [7:0] exp_sum_tbl;
    logic [7:0] exp_cout_tbl;
    logic [2:0] combo;

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        // Index i = {a,b,cin}; (sum,cout) = 00,10,10,01,10,01,01,11
        exp_sum_tbl  = 8'b1001_0110;
        exp_cout_tbl = 8'b1110_1000;

        // Reset held for two clocks
        next_cycle();
        next_cycle();
        #1;
        chk("rst_sum_q",  32'(if1.sum_q),     32'd0);
        chk("rst_cout_q", 32'(if1.cout_q),    32'd0);
        chk("rst_txn",    32'(if1.txn_count), 32'd0);
        chk("rst_idle",   32'(if1.ap_idle),   32'd1);
        cmp_en = 1'b1;
        next_cycle();
        rst = 1'b0;

        // Exhaustive 1-bit table, one accepted pulse per combination
        for (int i = 0; i < 8; i++) begin
            combo   = 3'(i);
            start   = 1'b1;
            if1.a   = combo[2];
            if1.b   = combo[1];
            if1.cin = combo[0];
            rand_w4();
            #1;
            chk("tbl_sum",  32'(if1.sum),  32'(exp_sum_tbl[i]));
            chk("tbl_cout", 32'(if1.cout), 32'(exp_cout_tbl[i]));
            chk("tbl_hs",   {28'd0, if1.sum_ap_vld, if1.cout_ap_vld, if1.ap_done, if1.ap_ready}, 32'hF);
            next_cycle();
        end

        // Idle request: results still flow, qualifiers drop
        start = 1'b0;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
        #1;
        chk("cap_txn8",    32'(if1.txn_count), 32'd8);
        chk("cap_sum_q",   32'(if1.sum_q),     32'd1);
        chk("cap_cout_q",  32'(if1.cout_q),    32'd1);
        chk("nostart_sum", 32'(if1.sum),       32'd0);
        chk("nostart_cout", 32'(if1.cout),     32'd1);
        chk("nostart_hs",  {28'd0, if1.sum_ap_vld, if1.cout_ap_vld, if1.ap_done, if1.ap_ready}, 32'd0);

        // Five idle clocks with churning operands must not disturb capture
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if1.a = 1'($urandom_range(0, 1));
            if1.b = 1'($urandom_range(0, 1));
            if1.cin = 1'($urandom_range(0, 1));
            rand_w4();
        end
        #1;
        chk("hold_sum_q",  32'(if1.sum_q),     32'd1);
        chk("hold_cout_q", 32'(if1.cout_q),    32'd1);
        chk("hold_txn",    32'(if1.txn_count), 32'd8);

        // 4-bit boundary cases
        next_cycle();
        if4.a = 4'hF; if4.b = 4'h1; if4.cin = 1'b0;
        #1;
        chk("w4_f_1_sum",  32'(if4.sum),  32'h0);
        chk("w4_f_1_cout", 32'(if4.cout), 32'd1);
        if4.a = 4'h7; if4.b = 4'h8; if4.cin = 1'b1;
        #1;
        chk("w4_7_8_sum",  32'(if4.sum),  32'h0);
        chk("w4_7_8_cout", 32'(if4.cout), 32'd1);
        if4.a = 4'hF; if4.b = 4'hF; if4.cin = 1'b1;
        #1;
        chk("w4_ones_sum",  32'(if4.sum),  32'hF);
        chk("w4_ones_cout", 32'(if4.cout), 32'd1);

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            start   = ($urandom_range(0, 9) < 7);
            if1.a   = 1'($urandom_range(0, 1));
            if1.b   = 1'($urandom_range(0, 1));
            if1.cin = 1'($urandom_range(0, 1));
            rand_w4();
        end

        // Reset arriving together with a request
        next_cycle();
        rst   = 1'b1;
        start = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
        #1;
        chk("rstmid_sum",  32'(if1.sum),        32'd1);
        chk("rstmid_cout", 32'(if1.cout),       32'd1);
        chk("rstmid_vld",  32'(if1.sum_ap_vld), 32'd1);
        chk("rstmid_done", 32'(if1.ap_done),    32'd1);
        next_cycle();
        chk("rstmid_sum_q",  32'(if1.sum_q),     32'd0);
        chk("rstmid_cout_q", 32'(if1.cout_q),    32'd0);
        chk("rstmid_txn",    32'(if1.txn_count), 32'd0);
        rst = 1'b0;

        // A little more traffic after recovery
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            start   = 1'($urandom_range(0, 1));
            if1.a   = 1'($urandom_range(0, 1));
            if1.b   = 1'($urandom_range(0, 1));
            if1.cin = 1'($urandom_range(0, 1));
            rand_w4();
        end
        next_cycle();
        start = 1'b0;
        next_cycle();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
